// File: rtl/bram_ddr_responder_pkg.sv
// Shared types and constants for the block-RAM stand-in of the DDR request/acknowledge responder.
package bram_ddr_responder_pkg;

  localparam int unsigned BUS_ADDR_W    = 24;
  localparam int unsigned DATA_W        = 16;
  localparam int unsigned WORDS_PER_ROW = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ACK   = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_REFRESH = 2'd0,
    OP_WRITE   = 2'd1,
    OP_READ    = 2'd2
  } op_t;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_word_t;

  // Largest of the three op latencies; sizes the latency counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/bram_ddr_responder_if.sv
// Memory request/acknowledge bus between the frame-buffer controller and its memory responder.
interface bram_ddr_responder_if;
  import bram_ddr_responder_pkg::*;

  logic                  read;
  logic [BUS_ADDR_W-1:0] readAddress;
  logic                  readAcknowledge;
  logic [DATA_W-1:0]     readData;

  logic                  write;
  logic [BUS_ADDR_W-1:0] writeAddress;
  logic [DATA_W-1:0]     writeData;
  logic                  writeAcknowledge;

  logic                  refresh;
  logic                  refreshAcknowledge;

  modport master (
    output read, readAddress, write, writeAddress, writeData, refresh,
    input  readAcknowledge, readData, writeAcknowledge, refreshAcknowledge
  );

  modport slave (
    input  read, readAddress, write, writeAddress, writeData, refresh,
    output readAcknowledge, readData, writeAcknowledge, refreshAcknowledge
  );

endinterface

// File: rtl/bram_ddr_responder_word_ram.sv
// Single-port synchronous word RAM with one-cycle read latency; maps onto block RAM.
module bram_ddr_responder_word_ram #(
  parameter int unsigned ADDR_BITS = 15,
  parameter int unsigned DATA_W    = 16
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_W-1:0]    din,
  output logic [DATA_W-1:0]    dout
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-before-write: dout shows the old word on a write cycle.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/bram_ddr_responder.sv
// Serves refresh/write/read requests from on-chip RAM with per-word acknowledge timing set by
// parameters. The accept cycle in IDLE counts as the first latency cycle; word period is latency+2.
module bram_ddr_responder
  import bram_ddr_responder_pkg::*;
#(
  parameter int unsigned ADDR_BITS      = 15,
  parameter int unsigned READ_LATENCY   = 3,
  parameter int unsigned WRITE_LATENCY  = 2,
  parameter int unsigned REFRESH_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  bram_ddr_responder_if.slave  bus
);

  localparam int unsigned MAX_LAT = max3(READ_LATENCY, WRITE_LATENCY, REFRESH_CYCLES);
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  state_t               state_q, state_d;
  op_t                  op_q, op_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     lat_c;
  logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
  logic                 go_ack_c;
  logic                 req_c;

  wr_word_t             wr_c;
  logic                 ram_we_c;
  logic [ADDR_BITS-1:0] ram_addr_c;
  logic [DATA_W-1:0]    ram_dout;

  assign wr_c = '{addr: bus.writeAddress, data: bus.writeData};

  // Address bits above the RAM depth alias by design.
  if (ADDR_BITS < BUS_ADDR_W) begin : g_alias
    logic unused_hi;
    assign unused_hi = ^{bus.readAddress[BUS_ADDR_W-1:ADDR_BITS],
                         wr_c.addr[BUS_ADDR_W-1:ADDR_BITS]};
  end

  // Request level belonging to the op currently being served.
  always_comb begin
    req_c = 1'b0;
    case (op_q)
      OP_REFRESH: req_c = bus.refresh;
      OP_WRITE:   req_c = bus.write;
      OP_READ:    req_c = bus.read;
      default:    req_c = 1'b0;
    endcase
  end

  // Arbitration, latency countdown and ack sequencing.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    rd_addr_d = rd_addr_q;
    lat_c     = '0;
    go_ack_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.refresh) begin
          op_d  = OP_REFRESH;
          lat_c = CNT_W'(REFRESH_CYCLES);
        end else if (bus.write) begin
          op_d  = OP_WRITE;
          lat_c = CNT_W'(WRITE_LATENCY);
        end else if (bus.read) begin
          op_d  = OP_READ;
          lat_c = CNT_W'(READ_LATENCY);
        end

        if (bus.refresh || bus.write || bus.read) begin
          rd_addr_d = bus.readAddress[ADDR_BITS-1:0];
          if (lat_c == CNT_W'(1)) begin
            state_d  = ST_ACK;
            go_ack_c = 1'b1;
          end else begin
            state_d = ST_SERVE;
            cnt_d   = lat_c - CNT_W'(1);
          end
        end
      end

      ST_SERVE: begin
        if (!req_c) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_ACK;
          go_ack_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_ACK:  state_d = ST_GAP;
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Writes commit on the ack edge with whatever address/data is presented at that edge.
  assign ram_we_c = go_ack_c && (op_d == OP_WRITE) && !rst;

  always_comb begin
    ram_addr_c = bus.readAddress[ADDR_BITS-1:0];
    if (state_q == ST_SERVE && op_q == OP_READ) ram_addr_c = rd_addr_q;
    if (ram_we_c) ram_addr_c = wr_c.addr[ADDR_BITS-1:0];
  end

  bram_ddr_responder_word_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_W    (DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_c),
    .addr (ram_addr_c),
    .din  (wr_c.data),
    .dout (ram_dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q                <= ST_IDLE;
      op_q                   <= OP_READ;
      cnt_q                  <= '0;
      rd_addr_q              <= '0;
      bus.readAcknowledge    <= 1'b0;
      bus.writeAcknowledge   <= 1'b0;
      bus.refreshAcknowledge <= 1'b0;
      bus.readData           <= '0;
    end else begin
      state_q                <= state_d;
      op_q                   <= op_d;
      cnt_q                  <= cnt_d;
      rd_addr_q              <= rd_addr_d;
      bus.readAcknowledge    <= go_ack_c && (op_d == OP_READ);
      bus.writeAcknowledge   <= go_ack_c && (op_d == OP_WRITE);
      bus.refreshAcknowledge <= go_ack_c && (op_d == OP_REFRESH);
      if (go_ack_c && op_d == OP_READ) bus.readData <= ram_dout;
    end
  end

endmodule

// File: tb/tb_bram_ddr_responder.sv
// Directed + randomized bench for bram_ddr_responder against a word-addressed memory model.
module tb_bram_ddr_responder;

  localparam int AB = 15;
  localparam int RL = 3;
  localparam int WL = 2;
  localparam int RC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [15:0] model [int];
  int          written [$];

  bram_ddr_responder_if bus();

  bram_ddr_responder #(
    .ADDR_BITS      (AB),
    .READ_LATENCY   (RL),
    .WRITE_LATENCY  (WL),
    .REFRESH_CYCLES (RC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int mask(input int a);
    return a & ((1 << AB) - 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for the next ack of any kind; it must be exactly the requested one.
  task automatic wait_ack(input int which, input string tag, output int at);
    logic [2:0] acks;
    bit seen;
    seen = 1'b0;
    at   = -1;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      acks = {bus.refreshAcknowledge, bus.writeAcknowledge, bus.readAcknowledge};
      if (acks != 3'b000) begin
        check({tag, "_ack_kind"}, 32'(acks), 32'(3'(3'b001 << which)));
        seen = 1'b1;
        at   = cyc;
      end
    end
    check({tag, "_ack_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic write_burst(input int base, input int n, input int dbase, input int rf_word);
    int raise, at, last;
    bus.writeAddress = 24'(base);
    bus.writeData    = 16'(dbase);
    bus.write        = 1'b1;
    raise = cyc;
    last  = cyc;
    for (int i = 0; i < n; i++) begin
      if (i == rf_word) begin
        repeat (3) tick();
        bus.refresh = 1'b1;
      end
      wait_ack(1, "wr_burst", at);
      if (i == 0) check("wr_first_latency", 32'(at - raise), 32'(WL));
      else        check("wr_period", 32'(at - last), 32'(WL + 2));
      model[mask(base + i)] = 16'(dbase + i);
      last = at;
      bus.writeAddress = 24'(base + i + 1);
      bus.writeData    = 16'(dbase + i + 1);
      if (i == n - 1) bus.write = 1'b0;
      if (i == rf_word) begin
        wait_ack(2, "rf_mid_burst", at);
        check("rf_after_word", 32'(at - last), 32'(RC + 2));
        bus.refresh = 1'b0;
        last = at;
      end
    end
    tick();
    tick();
  endtask

  // Read burst; abort_word >= 0 asserts rst while that word is being served.
  task automatic read_burst(input int base, input int n, input int abort_word);
    int raise, at, last;
    bus.readAddress = 24'(base);
    bus.read        = 1'b1;
    raise = cyc;
    last  = cyc;
    for (int i = 0; i < n; i++) begin
      if (i == abort_word) begin
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("rst_mid_rd_ack", 32'({bus.refreshAcknowledge, bus.writeAcknowledge,
                                     bus.readAcknowledge}), 32'd0);
        check("rst_mid_rd_data", 32'(bus.readData), 32'd0);
        bus.read = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        return;
      end
      wait_ack(0, "rd_burst", at);
      if (i == 0) check("rd_first_latency", 32'(at - raise), 32'(RL));
      else        check("rd_period", 32'(at - last), 32'(RL + 2));
      check("rd_burst_data", 32'(bus.readData), 32'(model[mask(base + i)]));
      last = at;
      bus.readAddress = 24'(base + i + 1);
      if (i == n - 1) bus.read = 1'b0;
    end
    tick();
    tick();
  endtask

  task automatic do_write(input int addr, input logic [15:0] data);
    int raise, at;
    bus.writeAddress = 24'(addr);
    bus.writeData    = data;
    bus.write        = 1'b1;
    raise = cyc;
    wait_ack(1, "wr_single", at);
    check("wr_single_latency", 32'(at - raise), 32'(WL));
    model[mask(addr)] = data;
    written.push_back(addr);
    bus.write = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_read(input int addr);
    int raise, at;
    logic [15:0] got;
    bus.readAddress = 24'(addr);
    bus.read        = 1'b1;
    raise = cyc;
    wait_ack(0, "rd_single", at);
    check("rd_single_latency", 32'(at - raise), 32'(RL));
    check("rd_single_data", 32'(bus.readData), 32'(model[mask(addr)]));
    got = bus.readData;
    bus.read = 1'b0;
    tick();
    check("rd_data_held", 32'(bus.readData), 32'(got));
    tick();
  endtask

  initial begin
    int at_w, at_r, addr, raise;
    logic any_ack;
    logic [15:0] data;

    bus.read = 1'b0; bus.readAddress = '0;
    bus.write = 1'b0; bus.writeAddress = '0; bus.writeData = '0;
    bus.refresh = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("reset_acks", 32'({bus.refreshAcknowledge, bus.writeAcknowledge,
                              bus.readAcknowledge}), 32'd0);
    check("reset_rdata", 32'(bus.readData), 32'd0);
    rst = 1'b0;
    tick();
    tick();

    // 40-word write burst then read it back
    write_burst(32'h40, 40, 32'hA000, -1);
    read_burst(32'h40, 40, -1);

    // Refresh raised while word 17 of a write burst is in flight
    write_burst(32'h100, 40, 32'h5000, 17);
    read_burst(32'h100 + 16, 4, -1);

    // Read and write raised together: write goes first
    bus.writeAddress = 24'h200; bus.writeData = 16'h1234; bus.write = 1'b1;
    bus.readAddress  = 24'h41;  bus.read = 1'b1;
    raise = cyc;
    wait_ack(1, "rw_wr", at_w);
    check("rw_wr_latency", 32'(at_w - raise), 32'(WL));
    model[mask(32'h200)] = 16'h1234;
    bus.write = 1'b0;
    wait_ack(0, "rw_rd", at_r);
    check("rw_rd_after_wr", 32'(at_r - at_w), 32'(RL + 2));
    check("rw_rd_data", 32'(bus.readData), 32'(model[mask(32'h41)]));
    bus.read = 1'b0;
    tick();
    tick();
    do_read(32'h200);

    // Write dropped one cycle into SERVE: no ack, RAM untouched
    bus.writeAddress = 24'h45; bus.writeData = 16'hDEAD; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    any_ack = 1'b0;
    repeat (8) begin
      tick();
      any_ack = any_ack | bus.writeAcknowledge | bus.readAcknowledge | bus.refreshAcknowledge;
    end
    check("abort_no_ack", 32'(any_ack), 32'd0);
    do_read(32'h45);

    // Reset during a read burst, then earlier data still reads back
    read_burst(32'h40, 10, 3);
    any_ack = 1'b0;
    repeat (4) begin
      tick();
      any_ack = any_ack | bus.writeAcknowledge | bus.readAcknowledge | bus.refreshAcknowledge;
    end
    check("post_rst_quiet", 32'(any_ack), 32'd0);
    read_burst(32'h40, 8, -1);

    // Random single-word traffic, with deliberate aliasing above ADDR_BITS
    for (int k = 0; k < 24; k++) begin
      if (k % 3 == 2 && written.size() > 0)
        addr = written[written.size() - 1] ^ (1 << (AB + int'($urandom_range(0, 8))));
      else
        addr = int'($urandom_range(0, 32'hFF_FFFF));
      data = 16'($urandom);
      do_write(addr, data);
      do_read(written[$urandom_range(0, written.size() - 1)]);
      if (k % 3 == 2) do_read(written[written.size() - 2]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
